// File: rtl/fxp_add_arbiter.sv
// Round-robin share of one FixedPoint_Adder among NREQ valid/ready requesters; accept at N, result at N+2.
// No new grant while a result sits in HOLD; the result is held stable until res_ready.
module fxp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int WI   = 4,
  parameter int WF   = 4,
  parameter int WIO  = 4,
  parameter int WFO  = 4,
  parameter int SAT  = 1,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*(WI+WF)-1:0]  req_a,
  input  logic [NREQ*(WI+WF)-1:0]  req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIO+WFO-1:0]       res_data,
  output logic [IDW-1:0]           res_id,
  output logic                     res_ovf,
  output logic [NREQ-1:0]          ovf_sticky,
  input  logic                     clr_ovf
);
  localparam int W  = WI + WF;
  localparam int WO = WIO + WFO;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [WO-1:0] SAT_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] SAT_MIN = {1'b1, {(WO-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [WO-1:0]   data_q, data_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic            vld_q, vld_d;
  logic            ovf_q, ovf_d;
  logic [NREQ-1:0] stk_q, stk_d;

  logic            found;
  logic [IDW-1:0]  win;
  int              cand;
  logic [NREQ-1:0] grant;
  logic [WO-1:0]   sum;
  logic            sum_ovf;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == ST_IDLE && found) begin
      grant[win] = 1'b1;
    end
  end

  // Gated by rst_n so no requester sees a grant while reset is held.
  assign req_ready = rst_n ? grant : '0;

  FixedPoint_Adder #(
    .WI1 (WI),
    .WF1 (WF),
    .WI2 (WI),
    .WF2 (WF),
    .WIO (WIO),
    .WFO (WFO)
  ) u_add (
    .in1      (a_q),
    .in2      (b_q),
    .out      (sum),
    .overFlow (sum_ovf)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    rid_d   = rid_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;
    stk_d   = clr_ovf ? '0 : stk_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          a_d  = req_a[int'(win)*W +: W];
          b_d  = req_b[int'(win)*W +: W];
          id_d = win;
          if (int'(win) == NREQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = win + 1'b1;
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Overflow needs same-sign operands, so A's sign gives the clamp direction.
        if (SAT != 0 && sum_ovf) begin
          data_d = a_q[W-1] ? SAT_MIN : SAT_MAX;
        end else begin
          data_d = sum;
        end
        ovf_d = sum_ovf;
        rid_d = id_q;
        if (sum_ovf) begin
          stk_d[id_q] = 1'b1;
        end
        vld_d   = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      rid_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      stk_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      rid_q   <= rid_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      stk_q   <= stk_d;
    end
  end

  assign res_valid  = vld_q;
  assign res_data   = data_q;
  assign res_id     = rid_q;
  assign res_ovf    = ovf_q;
  assign ovf_sticky = stk_q;

endmodule

// Signed fixed-point adder: aligns binary points, sums at full precision, truncates extra fraction
// bits and flags overflow when the integer part does not fit in WIO bits; out is the wrapped value.
module FixedPoint_Adder #(
  parameter int WI1 = 4,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 4,
  parameter int WIO = 4,
  parameter int WFO = 4
) (
  input  logic [WI1+WF1-1:0] in1,
  input  logic [WI2+WF2-1:0] in2,
  output logic [WIO+WFO-1:0] out,
  output logic               overFlow
);
  localparam int FW0 = (WF1 > WF2) ? WF1 : WF2;
  localparam int FW  = (FW0 > WFO) ? FW0 : WFO;
  localparam int IW0 = ((WI1 > WI2) ? WI1 : WI2) + 1;
  localparam int IW  = (IW0 > WIO) ? IW0 : WIO;
  localparam int EW  = IW + FW;
  localparam int WO  = WIO + WFO;

  logic signed [EW-1:0] x1, x2, s, t;

  assign x1 = $signed({{(EW-WI1-WF1){in1[WI1+WF1-1]}}, in1}) <<< (FW - WF1);
  assign x2 = $signed({{(EW-WI2-WF2){in2[WI2+WF2-1]}}, in2}) <<< (FW - WF2);
  assign s  = x1 + x2;
  assign t  = s >>> (FW - WFO);

  assign out = t[WO-1:0];
  // In range only if every bit above the result's sign bit repeats it.
  assign overFlow = !((&t[EW-1:WO-1]) || !(|t[EW-1:WO-1]));

endmodule
